// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC path.
// Holds the collector FSM states and saturation helpers.
package mac_pkg;

    localparam int PROD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        WAIT_HI,
        WAIT_LO,
        ACCUM,
        DONE
    } state_t;

    // Bit patterns live in the low w bits of the result.
    function automatic logic [31:0] sat_max(input int w);
        return (32'h1 << (w - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return 32'h1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed saturating add of a 16-bit product into an ACC_W accumulator.
// Computed at ACC_W+1 bits, clamped to the ACC_W signed range.
module sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0]  base,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] wide;

    assign wide = {base[ACC_W-1], base}
                + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};

    // Top two bits disagree only when the result left the ACC_W range.
    assign ovf = wide[ACC_W] ^ wide[ACC_W-1];

    always_comb begin
        sum = wide[ACC_W-1:0];
        if (ovf) begin
            sum = wide[ACC_W] ? MIN : MAX;
        end
    end

endmodule

// File: rtl/booth_prod_acc.sv
// Collects byte-serial Booth products and sums NUM_TERMS of them
// into a saturating accumulator, strobing done_o per frame.
module booth_prod_acc
    import mac_pkg::*;
#(
    parameter int NUM_TERMS = 4,
    parameter int ACC_W     = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] inbus_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic              ready_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic              err_o
);

    state_t state;
    state_t state_nx;

    logic [BYTE_W-1:0] hi_reg;
    logic [BYTE_W-1:0] lo_reg;
    logic [7:0]        count;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  sum;
    logic              sat;
    logic              last;
    logic              ovf;
    logic              err;

    assign last = (count + 8'd1) == 8'(NUM_TERMS);

    // First term of a frame loads instead of adding.
    assign base = (count == 8'd0) ? '0 : acc;

    sat_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .base(base),
        .prod({hi_reg, lo_reg}),
        .sum (sum),
        .ovf (sat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WAIT_HI;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clear_i) begin
            state_nx = WAIT_HI;
        end else begin
            unique case (state)
                WAIT_HI: if (valid_i) state_nx = WAIT_LO;
                WAIT_LO: if (valid_i) state_nx = ACCUM;
                ACCUM:   state_nx = last ? DONE : WAIT_HI;
                DONE:    state_nx = WAIT_HI;
            endcase
        end
    end

    always_comb begin
        ready_o = (state == WAIT_HI) || (state == WAIT_LO);
        done_o  = (state == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            hi_reg <= '0;
            lo_reg <= '0;
            count  <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (state == WAIT_HI && valid_i) hi_reg <= inbus_i;
            if (state == WAIT_LO && valid_i) lo_reg <= inbus_i;
            if (state == ACCUM) begin
                acc   <= sum;
                count <= count + 8'd1;
                if (sat) ovf <= 1'b1;
            end
            if (state == DONE) count <= '0;
            if (valid_i && !ready_o) err <= 1'b1;
        end
    end

    assign acc_o = acc;
    assign ovf_o = ovf;
    assign err_o = err;

endmodule

// File: tb/tb_booth_prod_acc.sv
// Directed bench: three collector configurations share one byte bus,
// each gated by its own valid; clear and reset are common.
module tb_booth_prod_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bus = 8'h00;
    logic        valid = 1'b0;
    logic        clear = 1'b0;
    int          sel = 0;

    logic [2:0]  rdy, dn, ov, er;
    logic [19:0] acc0;
    logic [16:0] acc1, acc2;

    logic [31:0] cur_acc;
    logic        cur_rdy, cur_dn, cur_ov, cur_er;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_prod_acc #(.NUM_TERMS(4), .ACC_W(20)) u0 (
        .clk_i(clk), .rst_i(rst), .inbus_i(bus),
        .valid_i(valid && sel == 0), .clear_i(clear),
        .ready_o(rdy[0]), .acc_o(acc0), .done_o(dn[0]),
        .ovf_o(ov[0]), .err_o(er[0])
    );

    booth_prod_acc #(.NUM_TERMS(4), .ACC_W(17)) u1 (
        .clk_i(clk), .rst_i(rst), .inbus_i(bus),
        .valid_i(valid && sel == 1), .clear_i(clear),
        .ready_o(rdy[1]), .acc_o(acc1), .done_o(dn[1]),
        .ovf_o(ov[1]), .err_o(er[1])
    );

    booth_prod_acc #(.NUM_TERMS(5), .ACC_W(17)) u2 (
        .clk_i(clk), .rst_i(rst), .inbus_i(bus),
        .valid_i(valid && sel == 2), .clear_i(clear),
        .ready_o(rdy[2]), .acc_o(acc2), .done_o(dn[2]),
        .ovf_o(ov[2]), .err_o(er[2])
    );

    always_comb begin
        cur_acc = 32'(acc0);
        if (sel == 1) cur_acc = 32'(acc1);
        if (sel == 2) cur_acc = 32'(acc2);
        cur_rdy = rdy[sel];
        cur_dn  = dn[sel];
        cur_ov  = ov[sel];
        cur_er  = er[sel];
    end

    typedef struct {
        int          inst;
        int          n;
        logic [15:0] p [5];
        logic [31:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sends hi then lo back to back; returns 1ns into the ACCUM cycle.
    task automatic put(input logic [15:0] p);
        bus = p[15:8];
        valid = 1'b1;
        @(posedge clk); #1;
        bus = p[7:0];
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic next_term();
        @(posedge clk); #1;
    endtask

    // Called during ACCUM of the last term.
    task automatic end_frame(input string tag, input logic [31:0] exp,
                             input logic exp_ovf);
        chk({tag, " done_accum"}, 32'(cur_dn), 32'd0);
        @(posedge clk); #1;
        chk({tag, " done"}, 32'(cur_dn), 32'd1);
        chk({tag, " acc"}, cur_acc, exp);
        chk({tag, " ovf"}, 32'(cur_ov), 32'(exp_ovf));
        @(posedge clk); #1;
        chk({tag, " done_after"}, 32'(cur_dn), 32'd0);
        chk({tag, " ready_after"}, 32'(cur_rdy), 32'd1);
        chk({tag, " acc_hold"}, cur_acc, exp);
    endtask

    initial begin
        vecs[0].inst = 0; vecs[0].n = 4;
        vecs[0].p = '{16'h000F, 16'hFFF2, 16'h0064, 16'h0001, 16'h0000};
        vecs[0].exp_acc = 32'h00066; vecs[0].exp_ovf = 1'b0;
        vecs[1].inst = 0; vecs[1].n = 4;
        vecs[1].p = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[1].exp_acc = 32'hFFFFC; vecs[1].exp_ovf = 1'b0;
        vecs[2].inst = 1; vecs[2].n = 4;
        vecs[2].p = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000};
        vecs[2].exp_acc = 32'h0FFFF; vecs[2].exp_ovf = 1'b1;
        vecs[3].inst = 1; vecs[3].n = 4;
        vecs[3].p = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
        vecs[3].exp_acc = 32'h00004; vecs[3].exp_ovf = 1'b1;
        vecs[4].inst = 2; vecs[4].n = 5;
        vecs[4].p = '{16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000};
        vecs[4].exp_acc = 32'h10000; vecs[4].exp_ovf = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst ready", 32'(cur_rdy), 32'd1);
        chk("rst acc", cur_acc, 32'd0);
        chk("rst done", 32'(cur_dn), 32'd0);
        chk("rst ovf", 32'(cur_ov), 32'd0);
        chk("rst err", 32'(cur_er), 32'd0);

        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].inst;
            for (int k = 0; k < vecs[i].n; k++) begin
                put(vecs[i].p[k]);
                if (k < vecs[i].n - 1) next_term();
            end
            end_frame($sformatf("vec%0d", i), vecs[i].exp_acc,
                      vecs[i].exp_ovf);
        end

        // Sticky overflow survives a frame, then clear drops it.
        sel = 1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear ovf", 32'(cur_ov), 32'd0);
        chk("clear acc", cur_acc, 32'd0);

        // Stray byte during ACCUM.
        sel = 0;
        put(16'h0001); next_term();
        put(16'h0002);
        chk("accum ready", 32'(cur_rdy), 32'd0);
        bus = 8'h7F;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("stray err", 32'(cur_er), 32'd1);
        chk("stray ready", 32'(cur_rdy), 32'd1);
        put(16'h0003); next_term();
        put(16'h0004);
        end_frame("stray", 32'h0000A, 1'b0);
        chk("err sticky", 32'(cur_er), 32'd1);

        // Clear beats valid in WAIT_LO.
        bus = 8'h12;
        valid = 1'b1;
        @(posedge clk); #1;
        bus = 8'h34;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        valid = 1'b0;
        chk("clr acc", cur_acc, 32'd0);
        chk("clr err", 32'(cur_er), 32'd0);
        chk("clr ready", 32'(cur_rdy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            put(16'h0005);
            if (k < 3) next_term();
        end
        end_frame("postclr", 32'h00014, 1'b0);

        // Reset after a lone high byte.
        bus = 8'h7E;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2 ready", 32'(cur_rdy), 32'd1);
        chk("rst2 acc", cur_acc, 32'd0);
        chk("rst2 done", 32'(cur_dn), 32'd0);
        chk("rst2 ovf", 32'(cur_ov), 32'd0);
        chk("rst2 err", 32'(cur_er), 32'd0);
        for (int k = 0; k < 4; k++) begin
            put(16'h0100);
            if (k < 3) next_term();
        end
        end_frame("postrst", 32'h00400, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
